mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage data-memory access controller. It consumes the EX/MEM pipeline register outputs (address, store data, MemRead/MemWrite, ByteSel) and runs a req/ack transaction to data memory. It performs little-endian byte-lane steering for stores and lane extraction with sign extension for loads. It drives Stall_Out, which the pipeline uses to deassert EX/MEM WriteEnable until the access completes.

Parameters:
TIMEOUT_CYCLES, 64, cycles in REQ without MemAck before the access is aborted
CNT_WIDTH, 7, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
Clock  input  1  single clock; all state updates on the rising edge
Reset_n  input  1  asynchronous, active-low reset
MemRead_In  input  1  load request from the EX/MEM register
MemWrite_In  input  1  store request from the EX/MEM register
ByteSel_In  input  2  access size: 00 word, 01 half (sign-extended), 10 byte (sign-extended), 11 byte (zero-extended)
ALUResult_In  input  32  byte address
WriteData_In  input  32  store data, right-justified
ReadData_Out  output  32  formatted load result
Stall_Out  output  1  pipeline hold request
AlignErr_Out  output  1  one-cycle pulse on a misaligned access
AccessErr_Out  output  1  one-cycle pulse on a timeout abort
MemReq  output  1  memory request, registered
MemWe  output  1  1 = write, 0 = read
MemAddr  output  32  word address: {ALUResult_In[31:2], 2'b00}
MemBE  output  4  byte enables
MemWData  output  32  lane-replicated store data
MemAck  input  1  memory completion, sampled in REQ
MemRData  input  32  read word, valid with MemAck

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - state=IDLE; counter=0.
  - MemReq, MemWe, MemBE, MemAddr, MemWData, ReadData_Out, AlignErr_Out, AccessErr_Out all 0.
  - Stall_Out=0.
  - A reset in mid-transaction drops MemReq immediately. No retry is attempted after reset.
- Request decode:
  - acc = MemRead_In | MemWrite_In.
  - If both are set, it is a write.
  - Misaligned: half with addr[0]=1, or word/ByteSel 11 treated as byte... (see below) word with addr[1:0]!=0.
- States:
  - IDLE:
    - If acc and aligned: latch MemAddr, MemWe, MemBE, MemWData; set MemReq=1; go to REQ.
    - If acc and misaligned: AlignErr_Out=1 for the next cycle; no memory access; stay in IDLE.
  - REQ:
    - MemReq is held high. Address, data and BE are stable. Counter increments each cycle.
    - On MemAck=1: MemReq=0 on the next edge. For a read, ReadData_Out captures the formatted MemRData. Go to DONE.
    - If counter reaches TIMEOUT_CYCLES-1 without MemAck: MemReq=0, AccessErr_Out pulse, ReadData_Out=0 for a read, go to DONE.
    - MemAck outside REQ is ignored.
  - DONE:
    - Lasts one cycle with Stall_Out=0, so the pipeline advances.
    - Counter clears; go to IDLE.
    - The old op is still present on the inputs during DONE and must not be relaunched.
- Stall_Out (combinational) = (IDLE & acc & aligned) | REQ. It is 0 in DONE and for a misaligned access.
- Latency: an aligned access with MemAck on its first REQ cycle stalls for 2 cycles. N wait cycles give N+2 stall cycles.
- Store lanes:
  - byte: MemBE = 1<<addr[1:0]; MemWData = {4{WriteData_In[7:0]}}.
  - half: MemBE = addr[1] ? 1100 : 0011; MemWData = {2{WriteData_In[15:0]}}.
  - word: MemBE = 1111; MemWData = WriteData_In.
- Reads: MemBE=1111.
- Load format (lane selected by addr):
  - byte: MemRData[8*addr[1:0]+:8], sign-extended (10) or zero-extended (11).
  - half: MemRData[16*addr[1]+:16], sign-extended.
  - word: passed through.
- ReadData_Out holds its value until the next read completes. Stores do not change it.
- Back-to-back accesses: a new op seen in IDLE the cycle after DONE launches with no bubble beyond DONE.

Test Plan:
- Word read, addr 0x100, MemAck on the 1st REQ cycle, MemRData=0xDEADBEEF -> MemReq high 1 cycle, MemBE=1111, Stall 2 cycles, ReadData_Out=0xDEADBEEF.
- Byte write, addr 0x203, data 0x000000A5 -> MemAddr=0x200, MemBE=1000, MemWData=0xA5A5A5A5, MemWe=1.
- Signed byte load (ByteSel 10) and unsigned byte load (ByteSel 11), addr 0x1, MemRData=0x0000F000 -> ReadData_Out=0xFFFFFFF0, then 0x000000F0.
- Half read at addr 0x3 -> AlignErr_Out pulse, MemReq stays 0, Stall_Out=0.
- MemAck never asserted -> MemReq drops after 64 REQ cycles, AccessErr_Out pulse, ReadData_Out=0, pipeline released.
- Reset_n low during REQ mid-wait -> MemReq=0 and Stall_Out=0 asynchronously, state IDLE, ReadData_Out=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack handshake to data memory,
// little-endian store lane steering and load lane extraction with sign extension.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 7
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [1:0]  ByteSel_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] WriteData_In,
  output logic [31:0] ReadData_Out,
  output logic        Stall_Out,
  output logic        AlignErr_Out,
  output logic        AccessErr_Out,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_TMAX = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_bsel;
  logic [1:0]           r_lane;

  logic        w_acc;
  logic        w_wr;
  logic        w_misal;
  logic        w_launch;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  function automatic logic [31:0] fmt_load(input logic [1:0]  bsel,
                                           input logic [1:0]  lane,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (bsel)
      2'b00:   return rdata;
      2'b01:   return {{16{h[15]}}, h};
      2'b10:   return {{24{b[7]}}, b};
      default: return {24'd0, b};
    endcase
  endfunction

  // Byte accesses can never be misaligned; a write wins when both requests are set.
  assign w_acc     = MemRead_In | MemWrite_In;
  assign w_wr      = MemWrite_In;
  assign w_misal   = ((ByteSel_In == 2'b01) && ALUResult_In[0]) ||
                     ((ByteSel_In == 2'b00) && (ALUResult_In[1:0] != 2'b00));
  assign w_launch  = (r_state == S_IDLE) && w_acc && !w_misal;
  assign w_timeout = (r_cnt == LP_TMAX);

  always_comb begin
    w_be    = 4'hF;
    w_wdata = WriteData_In;
    if (w_wr) begin
      case (ByteSel_In)
        2'b00: begin
          w_be    = 4'hF;
          w_wdata = WriteData_In;
        end
        2'b01: begin
          w_be    = ALUResult_In[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{WriteData_In[15:0]}};
        end
        default: begin
          w_be    = 4'b0001 << ALUResult_In[1:0];
          w_wdata = {4{WriteData_In[7:0]}};
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Held in reset, the pipeline must see no stall even if an op sits on the inputs.
  always_comb begin
    w_next    = r_state;
    Stall_Out = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_next    = S_REQ;
          Stall_Out = Reset_n;
        end
      end
      S_REQ: begin
        Stall_Out = Reset_n;
        if (MemAck || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt         <= '0;
      r_bsel        <= 2'b00;
      r_lane        <= 2'b00;
      MemReq        <= 1'b0;
      MemWe         <= 1'b0;
      MemAddr       <= 32'd0;
      MemBE         <= 4'd0;
      MemWData      <= 32'd0;
      ReadData_Out  <= 32'd0;
      AlignErr_Out  <= 1'b0;
      AccessErr_Out <= 1'b0;
    end else begin
      AlignErr_Out  <= (r_state == S_IDLE) && w_acc && w_misal;
      AccessErr_Out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_launch) begin
            MemReq   <= 1'b1;
            MemWe    <= w_wr;
            MemAddr  <= {ALUResult_In[31:2], 2'b00};
            MemBE    <= w_be;
            MemWData <= w_wdata;
            r_bsel   <= ByteSel_In;
            r_lane   <= ALUResult_In[1:0];
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (MemAck) begin
            MemReq <= 1'b0;
            if (!MemWe) ReadData_Out <= fmt_load(r_bsel, r_lane, MemRData);
          end else if (w_timeout) begin
            MemReq        <= 1'b0;
            AccessErr_Out <= 1'b1;
            if (!MemWe) ReadData_Out <= 32'd0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        MemRead_In, MemWrite_In;
  logic [1:0]  ByteSel_In;
  logic [31:0] ALUResult_In, WriteData_In;
  logic [31:0] ReadData_Out;
  logic        Stall_Out, AlignErr_Out, AccessErr_Out;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  int n_vec = 0;
  int n_err = 0;

  int          g_stalls, g_reqs;
  logic        g_aerr, g_done_req, g_we;
  logic [3:0]  g_be;
  logic [31:0] g_addr, g_wdata;

  always #5 Clock = ~Clock;

  mem_access_unit #(.TIMEOUT_CYCLES(64), .CNT_WIDTH(7)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .ByteSel_In(ByteSel_In), .ALUResult_In(ALUResult_In),
    .WriteData_In(WriteData_In), .ReadData_Out(ReadData_Out),
    .Stall_Out(Stall_Out), .AlignErr_Out(AlignErr_Out),
    .AccessErr_Out(AccessErr_Out), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemBE(MemBE), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drop_inputs();
    MemRead_In   = 1'b0;
    MemWrite_In  = 1'b0;
    ByteSel_In   = 2'b00;
    ALUResult_In = 32'd0;
    WriteData_In = 32'd0;
  endtask

  // Entered just after a rising edge; returns just after the edge that ends DONE.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] bs,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int wait_n, input logic [31:0] rdat);
    int k;
    g_stalls = 0; g_reqs = 0; g_aerr = 0; g_done_req = 0;
    g_we = 0; g_be = 0; g_addr = 0; g_wdata = 0;
    MemRead_In = rd; MemWrite_In = wr; ByteSel_In = bs;
    ALUResult_In = a; WriteData_In = wd;
    for (k = 0; k < 200; k++) begin
      @(negedge Clock);
      if (MemReq) begin
        g_reqs++;
        g_be = MemBE; g_addr = MemAddr; g_wdata = MemWData; g_we = MemWe;
      end
      if (!Stall_Out) begin
        g_aerr     = AccessErr_Out;
        g_done_req = MemReq;
        break;
      end
      g_stalls++;
      MemAck   = MemReq && (g_reqs > wait_n);
      MemRData = rdat;
      @(posedge Clock); #1;
    end
    chk("access_bound", 32'(k < 200), 32'd1);
    MemAck = 1'b0;
    @(posedge Clock); #1;
    drop_inputs();
  endtask

  initial begin
    Reset_n = 1'b0;
    MemAck = 1'b0; MemRData = 32'd0;
    drop_inputs();
    #12;
    chk("rst_req",   32'(MemReq), 0);
    chk("rst_stall", 32'(Stall_Out), 0);
    chk("rst_rdata", ReadData_Out, 0);
    chk("rst_be",    32'(MemBE), 0);
    chk("rst_addr",  MemAddr, 0);
    chk("rst_errs",  32'({AlignErr_Out, AccessErr_Out}), 0);
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;

    // Word read, ack on first REQ cycle
    do_access(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, 0, 32'hDEADBEEF);
    chk("wr_stalls", 32'(g_stalls), 2);
    chk("wr_reqs",   32'(g_reqs), 1);
    chk("wr_be",     32'(g_be), 32'hF);
    chk("wr_addr",   g_addr, 32'h100);
    chk("wr_we",     32'(g_we), 0);
    chk("wr_done",   32'(g_done_req), 0);
    chk("wr_rdata",  ReadData_Out, 32'hDEADBEEF);

    // Byte store, two wait cycles
    do_access(1'b0, 1'b1, 2'b10, 32'h203, 32'h000000A5, 2, 32'h0);
    chk("bs_stalls", 32'(g_stalls), 4);
    chk("bs_addr",   g_addr, 32'h200);
    chk("bs_be",     32'(g_be), 32'h8);
    chk("bs_wdata",  g_wdata, 32'hA5A5A5A5);
    chk("bs_we",     32'(g_we), 1);
    chk("bs_keep",   ReadData_Out, 32'hDEADBEEF);

    // Half store to upper half
    do_access(1'b0, 1'b1, 2'b01, 32'h6, 32'h1234BEEF, 0, 32'h0);
    chk("hs_be",    32'(g_be), 32'hC);
    chk("hs_wdata", g_wdata, 32'hBEEFBEEF);
    chk("hs_addr",  g_addr, 32'h4);

    // Read+write together is a write
    do_access(1'b1, 1'b1, 2'b00, 32'h10, 32'hCAFEF00D, 0, 32'h0);
    chk("rw_we",    32'(g_we), 1);
    chk("rw_be",    32'(g_be), 32'hF);
    chk("rw_wdata", g_wdata, 32'hCAFEF00D);

    // Signed / unsigned byte loads at lane 1
    do_access(1'b1, 1'b0, 2'b10, 32'h1, 32'd0, 0, 32'h0000F000);
    chk("lb_rdata",  ReadData_Out, 32'hFFFFFFF0);
    do_access(1'b1, 1'b0, 2'b11, 32'h1, 32'd0, 1, 32'h0000F000);
    chk("lbu_rdata", ReadData_Out, 32'h000000F0);
    chk("lbu_stall", 32'(g_stalls), 3);

    // Signed half load from upper half
    do_access(1'b1, 1'b0, 2'b01, 32'h2, 32'd0, 0, 32'h80011234);
    chk("lh_rdata", ReadData_Out, 32'hFFFF8001);
    chk("lh_be",    32'(g_be), 32'hF);

    // Misaligned half read
    do_access(1'b1, 1'b0, 2'b01, 32'h3, 32'd0, 0, 32'h0);
    chk("mis_stall", 32'(g_stalls), 0);
    chk("mis_req",   32'(g_reqs), 0);
    @(negedge Clock);
    chk("mis_pulse", 32'(AlignErr_Out), 1);
    @(negedge Clock);
    chk("mis_clear", 32'(AlignErr_Out), 0);
    chk("mis_keep",  ReadData_Out, 32'hFFFF8001);
    @(posedge Clock); #1;

    // Reset mid-wait
    MemRead_In = 1'b1; ByteSel_In = 2'b00; ALUResult_In = 32'h40;
    repeat (3) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("ar_req",   32'(MemReq), 0);
    chk("ar_stall", 32'(Stall_Out), 0);
    chk("ar_rdata", ReadData_Out, 0);
    drop_inputs();
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("ar_idle", 32'({MemReq, Stall_Out}), 0);
    @(posedge Clock); #1;

    // Timeout with no ack
    do_access(1'b1, 1'b0, 2'b00, 32'h80, 32'd0, 1000, 32'h12345678);
    chk("to_reqs",   32'(g_reqs), 64);
    chk("to_stalls", 32'(g_stalls), 65);
    chk("to_aerr",   32'(g_aerr), 1);
    chk("to_rdata",  ReadData_Out, 0);
    @(negedge Clock);
    chk("to_aclr",   32'({AccessErr_Out, MemReq, Stall_Out}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
